// File: rtl/fb_arbiter.sv
// Single-port framebuffer arbiter: display reads win, buffered pixel writes and
// a full-screen clear engine share the remaining RAM slots.
module fb_arbiter #(
  parameter int H_ACTIVE   = 640,
  parameter int V_ACTIVE   = 480,
  parameter int ADDR_W     = 19,
  parameter int FIFO_DEPTH = 16
) (
  input  logic              clock_25,
  input  logic              rst,
  input  logic              disp_req,
  input  logic [9:0]        disp_x,
  input  logic [9:0]        disp_y,
  output logic [7:0]        color_out,
  output logic              color_valid,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [9:0]        wr_x,
  input  logic [9:0]        wr_y,
  input  logic [7:0]        wr_data,
  output logic              wr_drop,
  input  logic              clr_start,
  input  logic [7:0]        clr_color,
  output logic              clr_busy,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [7:0]        mem_wdata,
  input  logic [7:0]        mem_rdata
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam int ENT_W = ADDR_W + 8;
  localparam logic [ADDR_W-1:0] H_A   = ADDR_W'(H_ACTIVE);
  localparam logic [ADDR_W-1:0] LAST  = ADDR_W'(H_ACTIVE * V_ACTIVE - 1);
  localparam logic [10:0]       X_LIM = 11'(H_ACTIVE);
  localparam logic [10:0]       Y_LIM = 11'(V_ACTIVE);
  localparam logic [CNT_W-1:0]  DEPTH = CNT_W'(FIFO_DEPTH);

  typedef enum logic {IDLE, CLEAR} state_t;
  typedef enum logic [1:0] {SLOT_NONE, SLOT_READ, SLOT_CLR, SLOT_POP} slot_t;

  state_t state, state_nx;
  slot_t  slot;

  function automatic logic [ADDR_W-1:0] pix_addr(input logic [9:0] x, input logic [9:0] y);
    return ADDR_W'(y) * H_A + ADDR_W'(x);
  endfunction

  logic [ADDR_W-1:0] disp_addr, wr_addr;
  logic              in_range, accept, push, pop, full, empty, start_clr;

  logic [ENT_W-1:0]  fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  rd_ptr, wr_ptr;
  logic [CNT_W-1:0]  count;
  logic [ENT_W-1:0]  head;

  logic [ADDR_W-1:0] clr_cnt;
  logic [7:0]        clr_col;
  logic              rd_p1, rd_p2;

  assign disp_addr = pix_addr(disp_x, disp_y);
  assign wr_addr   = pix_addr(wr_x, wr_y);
  assign in_range  = ({1'b0, wr_x} < X_LIM) && ({1'b0, wr_y} < Y_LIM);

  assign full      = (count == DEPTH);
  assign empty     = (count == '0);
  assign wr_ready  = !full;
  assign accept    = wr_valid && !full;
  assign push      = accept && in_range;
  assign pop       = (slot == SLOT_POP);
  assign head      = fifo_mem[rd_ptr];

  assign clr_busy  = (state == CLEAR);
  assign start_clr = (state == IDLE) && clr_start;

  // Slot priority: display read, then clear write, then FIFO drain (IDLE only).
  always_comb begin
    slot     = SLOT_NONE;
    state_nx = state;
    if (disp_req)
      slot = SLOT_READ;
    else if (state == CLEAR)
      slot = SLOT_CLR;
    else if (!empty)
      slot = SLOT_POP;

    case (state)
      IDLE:    if (clr_start) state_nx = CLEAR;
      CLEAR:   if (slot == SLOT_CLR && clr_cnt == LAST) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clock_25 or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      clr_cnt <= '0;
      clr_col <= '0;
    end else begin
      state <= state_nx;
      if (start_clr) begin
        clr_cnt <= '0;
        clr_col <= clr_color;
      end else if (slot == SLOT_CLR) begin
        clr_cnt <= clr_cnt + ADDR_W'(1);
      end
    end
  end

  always_ff @(posedge clock_25) begin
    if (push)
      fifo_mem[wr_ptr] <= {wr_addr, wr_data};
  end

  always_ff @(posedge clock_25 or negedge rst) begin
    if (!rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      wr_drop <= 1'b0;
    end else begin
      wr_drop <= accept && !in_range;
      if (push)
        wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)
        rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clock_25 or negedge rst) begin
    if (!rst) begin
      mem_addr  <= '0;
      mem_we    <= 1'b0;
      mem_wdata <= '0;
    end else begin
      case (slot)
        SLOT_READ: begin
          mem_addr <= disp_addr;
          mem_we   <= 1'b0;
        end
        SLOT_CLR: begin
          mem_addr  <= clr_cnt;
          mem_we    <= 1'b1;
          mem_wdata <= clr_col;
        end
        SLOT_POP: begin
          mem_addr  <= head[ENT_W-1:8];
          mem_we    <= 1'b1;
          mem_wdata <= head[7:0];
        end
        default: mem_we <= 1'b0;
      endcase
    end
  end

  always_ff @(posedge clock_25 or negedge rst) begin
    if (!rst) begin
      rd_p1       <= 1'b0;
      rd_p2       <= 1'b0;
      color_valid <= 1'b0;
      color_out   <= '0;
    end else begin
      rd_p1       <= (slot == SLOT_READ);
      rd_p2       <= rd_p1;
      color_valid <= rd_p2;
      color_out   <= rd_p2 ? mem_rdata : '0;
    end
  end

endmodule
